// File: rtl/mp_regfile.sv
// mp_regfile: parametrised multi-port general register file.
// Two write ports (port 1 wins on an address clash), NREAD combinational
// read ports with optional write-to-read bypass, and a per-register pending
// scoreboard that lets decode detect RAW hazards.
module mp_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int TRACE    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREAD*ADDR_W-1:0]   ra,
  output logic [NREAD*DATA_W-1:0]   rd,
  output logic [NREAD-1:0]          rbusy,
  input  logic                      we0,
  input  logic [ADDR_W-1:0]         wa0,
  input  logic [DATA_W-1:0]         wd0,
  input  logic [31:0]               wpc0,
  input  logic                      we1,
  input  logic [ADDR_W-1:0]         wa1,
  input  logic [DATA_W-1:0]         wd1,
  input  logic [31:0]               wpc1,
  input  logic                      rsv_en,
  input  logic [ADDR_W-1:0]         rsv_a,
  input  logic                      flush
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;

  logic commit0;
  logic commit1;
  logic rsv_ok;

  // A port commits only if it is enabled, not aimed at a hard-wired zero
  // register, and (port 0 only) not shadowed by port 1 at the same address.
  assign commit1 = we1 && !((ZERO_REG != 0) && (wa1 == '0));
  assign commit0 = we0 && !((ZERO_REG != 0) && (wa0 == '0)) &&
                   !(we1 && (wa1 == wa0));
  assign rsv_ok  = rsv_en && !((ZERO_REG != 0) && (rsv_a == '0));

  // Register array: cleared on reset, otherwise both committed writes land.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (commit0) regs[wa0] <= wd0;
      if (commit1) regs[wa1] <= wd1;
    end
  end

  // Pending scoreboard: flush, then a new reservation, then a retiring write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (flush) begin
          pending[r] <= 1'b0;
        end else if (rsv_ok && (rsv_a == ADDR_W'(r))) begin
          pending[r] <= 1'b1;
        end else if ((commit0 && (wa0 == ADDR_W'(r))) ||
                     (commit1 && (wa1 == ADDR_W'(r)))) begin
          pending[r] <= 1'b0;
        end
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < NREAD; k++) begin : g_read
      logic [ADDR_W-1:0] addr;
      logic              hit0;
      logic              hit1;
      logic              is_zero;
      logic              byp_hit;
      logic [DATA_W-1:0] data;

      assign addr    = ra[k*ADDR_W +: ADDR_W];
      assign hit0    = we0 && (wa0 == addr);
      assign hit1    = we1 && (wa1 == addr);
      assign is_zero = (ZERO_REG != 0) && (addr == '0);
      assign byp_hit = (BYPASS != 0) && (hit0 || hit1);

      // Read mux: zero register, then port 1 bypass, port 0 bypass, array.
      always_comb begin
        data = regs[addr];
        if (is_zero) begin
          data = '0;
        end else if ((BYPASS != 0) && hit1) begin
          data = wd1;
        end else if ((BYPASS != 0) && hit0) begin
          data = wd0;
        end
      end

      assign rd[k*DATA_W +: DATA_W] = data;
      assign rbusy[k] = !is_zero && pending[addr] && !byp_hit;
    end
  endgenerate

`ifndef SYNTHESIS
  generate
    if (TRACE != 0) begin : g_trace
      // Simulation trace of committed writes, port 0 first.
      always_ff @(posedge clk) begin
        if (rst_n) begin
          if (commit0) $display("@%h: $%d <= %h", wpc0, wa0, wd0);
          if (commit1) $display("@%h: $%d <= %h", wpc1, wa1, wd1);
        end
      end
    end
  endgenerate
`endif

endmodule
